// File: rtl/ir_pkg.sv
// Shared constants for the IR key display: segment patterns and capture FSM states.
package ir_pkg;

    // Active-low pattern with only segment g lit and the decimal point off.
    localparam logic [7:0] SEG_DASH = 8'hBF;

    // Active-low hex patterns, dp off; index 0 is the rightmost entry.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    // Capture FSM; the unused encoding 2'd3 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low seven-segment pattern; blank_i forces a dash.
module hex_to_seg7
    import ir_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // Table lookup, overridden by the dash when the byte holds no key yet.
    always_comb begin
        seg_o = HEX_SEG_TABLE[nibble_i];
        if (blank_i) begin
            seg_o = SEG_DASH;
        end
    end

endmodule

// File: rtl/ir_key_display.sv
// IR key display: synchronises the decoder strobe, captures the last two key
// codes and a key counter, and scans them onto a 4-digit common-anode display.
module ir_key_display
    import ir_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       success,
    input  logic [7:0] data_code,
    output logic [7:0] seg,
    output logic [3:0] sel,
    output logic       key_valid,
    output logic [7:0] key_count
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             sync_meta_q;
    logic             s_sync_q;
    cap_state_e       state_q, state_d;
    logic [7:0]       cur_q, prev_q;
    logic             cur_vld_q, prev_vld_q;
    logic [7:0]       key_count_q;
    logic             key_valid_q;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic             scan_tc;
    logic [7:0]       seg_q;
    logic [3:0]       sel_q;
    logic [3:0]       nib_next;
    logic             blank_next;
    logic [7:0]       seg_next;

    // Two-flop synchroniser for the strobe from the decoder's clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta_q <= 1'b0;
            s_sync_q    <= 1'b0;
        end else begin
            sync_meta_q <= success;
            s_sync_q    <= sync_meta_q;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next state: one CAPTURE cycle per strobe, then wait for it to drop.
    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_sync_q) state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    if (!s_sync_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Key registers: shift cur into prev and load the new code during CAPTURE.
    // NOTE: these are plain flops, not a memory, so they take the reset and the
    // display shows dashes until real keys arrive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q       <= 8'h00;
            prev_q      <= 8'h00;
            cur_vld_q   <= 1'b0;
            prev_vld_q  <= 1'b0;
            key_count_q <= 8'h00;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= (state_q == CAPTURE);
            if (state_q == CAPTURE) begin
                prev_q      <= cur_q;
                prev_vld_q  <= cur_vld_q;
                cur_q       <= data_code;
                cur_vld_q   <= 1'b1;
                key_count_q <= key_count_q + 8'd1;
            end
        end
    end

    // Scan counter next state: digit index advances on the terminal count.
    always_comb begin
        scan_tc    = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        dig_d      = dig_q;
        if (scan_tc) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 2'd1;
        end
    end

    // Content of the digit about to be shown, so seg lands with its sel.
    always_comb begin
        nib_next   = cur_q[3:0];
        blank_next = !cur_vld_q;
        case (dig_d)
            2'd0: begin nib_next = cur_q[3:0];  blank_next = !cur_vld_q;  end
            2'd1: begin nib_next = cur_q[7:4];  blank_next = !cur_vld_q;  end
            2'd2: begin nib_next = prev_q[3:0]; blank_next = !prev_vld_q; end
            default: begin nib_next = prev_q[7:4]; blank_next = !prev_vld_q; end
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nib_next),
        .blank_i  (blank_next),
        .seg_o    (seg_next)
    );

    // Scan counter and display registers; seg and sel only change together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q <= '0;
            dig_q      <= 2'd0;
            seg_q      <= SEG_DASH;
            sel_q      <= 4'b1110;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            if (scan_tc) begin
                seg_q <= seg_next;
                sel_q <= ~(4'b0001 << dig_d);
            end
        end
    end

    assign seg       = seg_q;
    assign sel       = sel_q;
    assign key_valid = key_valid_q;
    assign key_count = key_count_q;

endmodule

// File: tb/tb_ir_key_display.sv
// Scoreboard bench for ir_key_display: stimulus queues expected key captures,
// a clocked monitor pops them on key_valid and checks the scanned display
// against a reference model of the last two keys.
module tb_ir_key_display;

    localparam int SD = 4;

    typedef struct {
        int         cap_edge;
        logic [7:0] code;
    } key_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       success;
    logic [7:0] data_code;
    logic [7:0] seg;
    logic [3:0] sel;
    logic       key_valid;
    logic [7:0] key_count;

    int n_cmp = 0;
    int n_err = 0;

    // Edges seen since reset release; the stimulus reads it to time captures.
    int       edge_n = 0;
    key_exp_t exp_q[$];

    // Reference model: last two keys, validity and count.
    logic [7:0] m_cur, m_prev;
    bit         m_cur_v, m_prev_v;
    int         m_cnt;
    logic [7:0] m_seg;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] sel_tbl [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    ir_key_display #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .success   (success),
        .data_code (data_code),
        .seg       (seg),
        .sel       (sel),
        .key_valid (key_valid),
        .key_count (key_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected pattern for digit d: low digits show cur, high digits prev; odd is the high nibble.
    function automatic logic [7:0] model_digit(input int d);
        logic [7:0] b;
        bit         v;
        int         nib;
        b   = (d < 2) ? m_cur : m_prev;
        v   = (d < 2) ? m_cur_v : m_prev_v;
        nib = (d % 2 == 1) ? (int'(b) / 16) : (int'(b) % 16);
        return v ? hex_tbl[nib] : 8'hBF;
    endfunction

    task automatic model_reset();
        m_cur = 8'h00; m_prev = 8'h00; m_cur_v = 0; m_prev_v = 0;
        m_cnt = 0; m_seg = 8'hBF; edge_n = 0;
        exp_q.delete();
    endtask

    // Monitor: display checked every cycle; key_valid pops the scoreboard.
    initial begin
        key_exp_t e;
        int       dg;
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) begin
                model_reset();
            end else begin
                edge_n++;
                dg = (edge_n / SD) % 4;
                // Digit change uses the key state from before this edge.
                if (edge_n % SD == 0) m_seg = model_digit(dg);
                #1;
                check("sel", 32'(sel), 32'(sel_tbl[dg]));
                check("seg", 32'(seg), 32'(m_seg));
                if (key_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_key_valid", 32'(key_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("key_valid_edge", 32'(edge_n), 32'(e.cap_edge));
                        m_prev = m_cur; m_prev_v = m_cur_v;
                        m_cur = e.code; m_cur_v = 1;
                        m_cnt = (m_cnt + 1) % 256;
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cap_edge <= edge_n) begin
                    // Expected pulse did not appear by its edge: record and resync.
                    e = exp_q.pop_front();
                    check("key_valid_missing", 32'(key_valid), 32'd1);
                    m_prev = m_cur; m_prev_v = m_cur_v;
                    m_cur = e.code; m_cur_v = 1;
                    m_cnt = (m_cnt + 1) % 256;
                end
                check("key_count", 32'(key_count), 32'(m_cnt));
            end
        end
    end

    // Raise success for hi clocks then hold it low for lo clocks.
    task automatic send_key(input logic [7:0] code, input int hi, input int lo);
        key_exp_t e;
        @(negedge clk);
        data_code = code;
        success   = 1'b1;
        // First sampled at the next edge k; key_valid follows edge k+3.
        e.cap_edge = edge_n + 4;
        e.code     = code;
        exp_q.push_back(e);
        repeat (hi) @(negedge clk);
        success = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        success   = 1'b0;
        data_code = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h0BF);
        check("rst_sel", 32'(sel), 32'h0E);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_count", 32'(key_count), 32'd0);
        reset = 1'b1;

        // Idle refresh: dashes on all four digits.
        repeat (20) @(negedge clk);

        // First and second keys, then a long pulse.
        send_key(8'h45, 20, 20);
        check("first_count", 32'(key_count), 32'd1);
        send_key(8'hA7, 20, 20);
        check("second_count", 32'(key_count), 32'd2);
        send_key(8'h3D, 1000, 20);
        check("long_count", 32'(key_count), 32'd3);

        // Randomised keys, pulse widths and gaps.
        repeat (40) begin
            send_key(8'($urandom_range(0, 255)), int'($urandom_range(3, 30)),
                     int'($urandom_range(2, 8)));
        end
        repeat (20) @(negedge clk);

        // Counter wrap from zero with 256 keys of 8'h00.
        do_reset();
        repeat (256) send_key(8'h00, 3, 2);
        repeat (20) @(negedge clk);
        check("wrap_count", 32'(key_count), 32'd0);

        // Reset asserted mid-cycle while the FSM holds a long strobe.
        @(negedge clk);
        data_code = 8'h3C;
        success   = 1'b1;
        begin
            key_exp_t e;
            e.cap_edge = edge_n + 4;
            e.code     = 8'h3C;
            exp_q.push_back(e);
        end
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_seg", 32'(seg), 32'h0BF);
        check("midrst_sel", 32'(sel), 32'h0E);
        check("midrst_key_valid", 32'(key_valid), 32'd0);
        check("midrst_key_count", 32'(key_count), 32'd0);
        success = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Normal capture after reset release.
        send_key(8'hE1, 6, 30);
        check("post_rst_count", 32'(key_count), 32'd1);
        repeat (30) @(negedge clk);

        check("pending_keys", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
